// File: rtl/mc_controller.sv
// mc_controller: control unit for the multicycle ARM core.
// Holds the main sequencing FSM, the ALU decoder, the instruction-field
// decoder and the condition logic with the architectural NZCV flags.
// The FSM registers the control word of the state it is entering, so the
// per-state controls come straight from flops. Only the reset override,
// the condition gating and the Instr-dependent fields are combinational.
module mc_controller (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:12] Instr,
    input  logic [3:0]   ALUFlags,
    output logic         PCWrite,
    output logic         MemWrite,
    output logic         RegWrite,
    output logic         IRWrite,
    output logic         AdrSrc,
    output logic [1:0]   RegSrc,
    output logic [1:0]   ALUSrcA,
    output logic [1:0]   ALUSrcB,
    output logic [1:0]   ResultSrc,
    output logic [1:0]   ImmSrc,
    output logic [1:0]   ALUControl
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    // Per-state control word. Write intents (regw, memw, branch) are
    // still ungated here; the condition logic qualifies them later.
    typedef struct packed {
        logic       nextpc;
        logic       irwrite;
        logic       regw;
        logic       memw;
        logic       branch;
        logic       aluop;
        logic       adrsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
    } ctrl_t;

    localparam ctrl_t CTRL_FETCH = '{
        nextpc: 1'b1, irwrite: 1'b1, regw: 1'b0, memw: 1'b0, branch: 1'b0,
        aluop: 1'b0, adrsrc: 1'b0, alusrca: 2'b01, alusrcb: 2'b10,
        resultsrc: 2'b10
    };

    // While reset is held the datapath sees the FETCH selects, but
    // nothing that writes architectural state is allowed to fire.
    localparam ctrl_t CTRL_RESET = '{
        nextpc: 1'b0, irwrite: 1'b0, regw: 1'b0, memw: 1'b0, branch: 1'b0,
        aluop: 1'b0, adrsrc: 1'b0, alusrca: 2'b01, alusrcb: 2'b10,
        resultsrc: 2'b10
    };

    // Instruction fields
    logic [3:0] cond_s;
    logic [1:0] op_s;
    logic [5:0] funct_s;
    logic [3:0] rd_s;
    logic       unused_rn_s;

    assign cond_s      = Instr[31:28];
    assign op_s        = Instr[27:26];
    assign funct_s     = Instr[25:20];
    assign rd_s        = Instr[15:12];
    assign unused_rn_s = ^Instr[19:16];

    state_t     state_r;
    ctrl_t      ctrl_r;
    ctrl_t      ctrl_eff_s;
    logic [3:0] flags_r;
    logic       condex_r;
    logic       condex_s;
    logic       nowrite_s;
    logic       cmp_s;
    logic [1:0] alu_dec_s;
    logic [1:0] alucontrol_s;
    logic [1:0] flagw_s;
    logic       pcs_s;

    // Sequencing: where the FSM goes from st for the current instruction.
    function automatic state_t next_state(input state_t st,
                                          input logic [1:0] op,
                                          input logic [5:0] funct);
        state_t ns;
        ns = S_FETCH;
        case (st)
            S_FETCH:    ns = S_DECODE;
            S_DECODE: begin
                case (op)
                    2'b00:   ns = funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   ns = S_MEMADR;
                    2'b10:   ns = S_BRANCH;
                    default: ns = S_FETCH;
                endcase
            end
            S_MEMADR:   ns = funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  ns = S_MEMWB;
            S_MEMWB:    ns = S_FETCH;
            S_MEMWRITE: ns = S_FETCH;
            S_EXECUTER: ns = S_ALUWB;
            S_EXECUTEI: ns = S_ALUWB;
            S_ALUWB:    ns = S_FETCH;
            S_BRANCH:   ns = S_FETCH;
            default:    ns = S_FETCH;
        endcase
        return ns;
    endfunction

    // Moore control word for a state. nowrite only matters for ALUWB,
    // where it cancels the register write of CMP and unknown commands.
    function automatic ctrl_t state_ctrl(input state_t st, input logic nowrite);
        ctrl_t c;
        c = CTRL_RESET;
        c.alusrca   = 2'b00;
        c.alusrcb   = 2'b00;
        c.resultsrc = 2'b00;
        case (st)
            S_FETCH:    c = CTRL_FETCH;
            S_DECODE: begin
                c.alusrca   = 2'b01;
                c.alusrcb   = 2'b10;
                c.resultsrc = 2'b10;
            end
            S_MEMADR:   c.alusrcb = 2'b01;
            S_MEMREAD:  c.adrsrc  = 1'b1;
            S_MEMWB: begin
                c.resultsrc = 2'b01;
                c.regw      = 1'b1;
            end
            S_MEMWRITE: begin
                c.adrsrc = 1'b1;
                c.memw   = 1'b1;
            end
            S_EXECUTER: c.aluop = 1'b1;
            S_EXECUTEI: begin
                c.alusrcb = 2'b01;
                c.aluop   = 1'b1;
            end
            S_ALUWB:    c.regw = ~nowrite;
            S_BRANCH: begin
                c.alusrcb   = 2'b01;
                c.resultsrc = 2'b10;
                c.branch    = 1'b1;
            end
            default:    c = CTRL_FETCH;
        endcase
        return c;
    endfunction

    // ARM condition-code evaluation against {N,Z,C,V}.
    function automatic logic cond_check(input logic [3:0] cond,
                                        input logic [3:0] flags);
        logic n, z, c, v, res;
        {n, z, c, v} = flags;
        case (cond)
            4'b0000: res = z;
            4'b0001: res = ~z;
            4'b0010: res = c;
            4'b0011: res = ~c;
            4'b0100: res = n;
            4'b0101: res = ~n;
            4'b0110: res = v;
            4'b0111: res = ~v;
            4'b1000: res = c & ~z;
            4'b1001: res = ~(c & ~z);
            4'b1010: res = (n == v);
            4'b1011: res = (n != v);
            4'b1100: res = ~z & (n == v);
            4'b1101: res = ~(~z & (n == v));
            4'b1110: res = 1'b1;
            4'b1111: res = 1'b1;
            default: res = 1'b1;
        endcase
        return res;
    endfunction

    // Main FSM: state and the registered control word of the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_FETCH;
            ctrl_r  <= CTRL_FETCH;
        end else begin
            state_r <= next_state(state_r, op_s, funct_s);
            ctrl_r  <= state_ctrl(next_state(state_r, op_s, funct_s), nowrite_s);
        end
    end

    // Reset override: FETCH selects with every write enable held low.
    always_comb begin
        ctrl_eff_s = ctrl_r;
        if (reset) begin
            ctrl_eff_s = CTRL_RESET;
        end else begin
            ctrl_eff_s = ctrl_r;
        end
    end

    // Command decode of funct[4:1]; CMP and unknown commands never write Rd.
    always_comb begin
        alu_dec_s = 2'b00;
        nowrite_s = 1'b0;
        cmp_s     = 1'b0;
        case (funct_s[4:1])
            4'b0100: alu_dec_s = 2'b00;
            4'b0010: alu_dec_s = 2'b01;
            4'b0000: alu_dec_s = 2'b10;
            4'b1100: alu_dec_s = 2'b11;
            4'b1010: begin
                alu_dec_s = 2'b01;
                nowrite_s = 1'b1;
                cmp_s     = 1'b1;
            end
            default: begin
                alu_dec_s = 2'b00;
                nowrite_s = 1'b1;
            end
        endcase
    end

    // ALU control and flag-write enables; C/V only follow arithmetic ops.
    always_comb begin
        alucontrol_s = 2'b00;
        flagw_s      = 2'b00;
        if (ctrl_eff_s.aluop) begin
            alucontrol_s = alu_dec_s;
            flagw_s[1]   = funct_s[0] | cmp_s;
            flagw_s[0]   = (funct_s[0] | cmp_s) & ~alu_dec_s[1];
        end else begin
            alucontrol_s = 2'b00;
            flagw_s      = 2'b00;
        end
    end

    assign condex_s = cond_check(cond_s, flags_r);

    // Architectural flags and the one-cycle-delayed condition result.
    // CondExR lets ALUWB use the pre-update flags of EXECUTE.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_r  <= 4'b0000;
            condex_r <= 1'b0;
        end else begin
            condex_r <= condex_s;
            if (flagw_s[1] & condex_s) begin
                flags_r[3:2] <= ALUFlags[3:2];
            end
            if (flagw_s[0] & condex_s) begin
                flags_r[1:0] <= ALUFlags[1:0];
            end
        end
    end

    assign pcs_s = ctrl_eff_s.branch | (ctrl_eff_s.regw & (rd_s == 4'b1111));

    assign PCWrite    = ctrl_eff_s.nextpc | (pcs_s & condex_r);
    assign MemWrite   = ctrl_eff_s.memw & condex_r;
    assign RegWrite   = ctrl_eff_s.regw & condex_r;
    assign IRWrite    = ctrl_eff_s.irwrite;
    assign AdrSrc     = ctrl_eff_s.adrsrc;
    assign ALUSrcA    = ctrl_eff_s.alusrca;
    assign ALUSrcB    = ctrl_eff_s.alusrcb;
    assign ResultSrc  = ctrl_eff_s.resultsrc;
    assign ALUControl = alucontrol_s;
    assign RegSrc     = {(op_s == 2'b01), (op_s == 2'b10)};
    assign ImmSrc     = op_s;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed ARM instruction sequences followed by random
// instructions, checked cycle by cycle against an instruction-level model.
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] instr;
    logic [3:0]  alu_flags;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
    logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;

    mc_controller dut (
        .clk(clk), .reset(reset), .Instr(instr), .ALUFlags(alu_flags),
        .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [3:0] m_flags;

    localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMREAD = 3,
                   P_MEMWB = 4, P_MEMWRITE = 5, P_EXECR = 6, P_EXECI = 7,
                   P_ALUWB = 8, P_BRANCH = 9;

    function automatic logic [19:0] hi(input logic [31:0] w);
        return w[31:12];
    endfunction

    // Condition pairs: even code tests a predicate, odd code its inverse.
    function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        {n, z, cf, v} = f;
        if (c[3:1] == 3'd7) return 1'b1;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            default: base = !z && (n == v);
        endcase
        return base ^ c[0];
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_all(input string ph, input logic [19:0] ins,
                              input logic pcw, input logic memw, input logic regw,
                              input logic irw, input logic adr, input logic [1:0] a,
                              input logic [1:0] b, input logic [1:0] r,
                              input logic [1:0] aluc);
        logic [1:0] op;
        op = ins[15:14];
        chk({ph, ".PCWrite"},    {3'b000, PCWrite},  {3'b000, pcw});
        chk({ph, ".MemWrite"},   {3'b000, MemWrite}, {3'b000, memw});
        chk({ph, ".RegWrite"},   {3'b000, RegWrite}, {3'b000, regw});
        chk({ph, ".IRWrite"},    {3'b000, IRWrite},  {3'b000, irw});
        chk({ph, ".AdrSrc"},     {3'b000, AdrSrc},   {3'b000, adr});
        chk({ph, ".ALUSrcA"},    {2'b00, ALUSrcA},   {2'b00, a});
        chk({ph, ".ALUSrcB"},    {2'b00, ALUSrcB},   {2'b00, b});
        chk({ph, ".ResultSrc"},  {2'b00, ResultSrc}, {2'b00, r});
        chk({ph, ".ALUControl"}, {2'b00, ALUControl}, {2'b00, aluc});
        chk({ph, ".RegSrc"},     {2'b00, RegSrc},    {2'b00, (op == 2'b01), (op == 2'b10)});
        chk({ph, ".ImmSrc"},     {2'b00, ImmSrc},    {2'b00, op});
    endtask

    // Runs one instruction from its FETCH cycle. Entry and exit point:
    // 1 time unit after a rising edge, DUT about to show FETCH.
    // rst_at >= 0 asserts reset in that cycle and holds it one more cycle.
    task automatic run_instr(input logic [19:0] ins, input logic fix,
                             input logic [3:0] ff, input int rst_at);
        logic [3:0] cond, rd, cmd;
        logic [1:0] op, aluc;
        logic [5:0] funct;
        logic pass, nowr, s, wr, pcd;
        int ph[$];
        cond = ins[19:16]; op = ins[15:14]; funct = ins[13:8]; rd = ins[3:0];
        cmd  = funct[4:1]; s = funct[0];
        pass = cond_holds(cond, m_flags);
        nowr = 1'b0;
        case (cmd)
            4'd4:    aluc = 2'b00;
            4'd2:    aluc = 2'b01;
            4'd0:    aluc = 2'b10;
            4'd12:   aluc = 2'b11;
            4'd10: begin aluc = 2'b01; nowr = 1'b1; s = 1'b1; end
            default: begin aluc = 2'b00; nowr = 1'b1; end
        endcase
        ph.push_back(P_FETCH);
        ph.push_back(P_DECODE);
        if (op == 2'b01) begin
            ph.push_back(P_MEMADR);
            if (funct[0]) begin ph.push_back(P_MEMREAD); ph.push_back(P_MEMWB); end
            else ph.push_back(P_MEMWRITE);
        end else if (op == 2'b00) begin
            ph.push_back(funct[5] ? P_EXECI : P_EXECR);
            ph.push_back(P_ALUWB);
        end else if (op == 2'b10) begin
            ph.push_back(P_BRANCH);
        end
        for (int i = 0; i < ph.size(); i++) begin
            instr     = ins;
            alu_flags = fix ? ff : 4'($urandom_range(0, 15));
            if (i == rst_at) begin
                reset = 1'b1;
                #1;
                expect_all("rst_hit", ins, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 2'b00);
                @(posedge clk); #1;
                expect_all("rst_hold", ins, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 2'b00);
                reset   = 1'b0;
                m_flags = 4'b0000;
                return;
            end
            #1;
            wr  = pass && !nowr;
            pcd = (rd == 4'hF);
            case (ph[i])
                P_FETCH:    expect_all("FETCH", ins, 1, 0, 0, 1, 0, 2'b01, 2'b10, 2'b10, 2'b00);
                P_DECODE:   expect_all("DECODE", ins, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 2'b00);
                P_MEMADR:   expect_all("MEMADR", ins, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00);
                P_MEMREAD:  expect_all("MEMREAD", ins, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00);
                P_MEMWB:    expect_all("MEMWB", ins, pass && pcd, 0, pass, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00);
                P_MEMWRITE: expect_all("MEMWRITE", ins, 0, pass, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00);
                P_EXECR:    expect_all("EXECR", ins, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, aluc);
                P_EXECI:    expect_all("EXECI", ins, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, aluc);
                P_ALUWB:    expect_all("ALUWB", ins, wr && pcd, 0, wr, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
                default:    expect_all("BRANCH", ins, pass, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00);
            endcase
            if ((ph[i] == P_EXECR || ph[i] == P_EXECI) && pass && s) begin
                m_flags[3:2] = alu_flags[3:2];
                if (aluc[1] == 1'b0) m_flags[1:0] = alu_flags[1:0];
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [3:0]  cond, rd, cmd;
        logic [1:0]  op;
        logic [5:0]  funct;
        logic [3:0]  cmds [6];
        int kind;
        cmds = '{4'd4, 4'd2, 4'd0, 4'd12, 4'd10, 4'd7};
        reset = 1'b1; instr = 20'h0; alu_flags = 4'h0; m_flags = 4'h0;
        @(posedge clk); #1;
        expect_all("reset", instr, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 2'b00);
        @(posedge clk); #1;
        reset = 1'b0;

        // 1: ADD; 2: LDR, STR
        run_instr(hi(32'hE0821003), 1'b0, 4'h0, -1);
        run_instr(hi(32'hE5910004), 1'b0, 4'h0, -1);
        run_instr(hi(32'hE5810004), 1'b0, 4'h0, -1);
        // 3: SUBS sets Z, BEQ taken; clear Z, BEQ not taken
        run_instr(hi(32'hE0500000), 1'b1, 4'b0100, -1);
        run_instr(hi(32'h0A000002), 1'b0, 4'h0, -1);
        run_instr(hi(32'hE0500000), 1'b1, 4'b0000, -1);
        run_instr(hi(32'h0A000002), 1'b0, 4'h0, -1);
        // 4: CMP, then BGE/BLT split on the 1010 flags
        run_instr(hi(32'hE1500001), 1'b1, 4'b1010, -1);
        run_instr(hi(32'hAA000002), 1'b0, 4'h0, -1);
        run_instr(hi(32'hBA000002), 1'b0, 4'h0, -1);
        // 5: ADDNE R15 with Z=1 then Z=0
        run_instr(hi(32'hE0500000), 1'b1, 4'b0100, -1);
        run_instr(hi(32'h1080F001), 1'b0, 4'h0, -1);
        run_instr(hi(32'hE1500001), 1'b1, 4'b0000, -1);
        run_instr(hi(32'h1080F001), 1'b0, 4'h0, -1);
        // 6: reset in MEMWRITE; flags cleared so BEQ falls through, BNE taken
        run_instr(hi(32'hE0500000), 1'b1, 4'b0100, -1);
        run_instr(hi(32'hE5810004), 1'b0, 4'h0, 3);
        run_instr(hi(32'h0A000002), 1'b0, 4'h0, -1);
        run_instr(hi(32'h1A000002), 1'b0, 4'h0, -1);

        // Random instruction mix
        for (int k = 0; k < 300; k++) begin
            kind = $urandom_range(0, 5);
            cond = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom_range(0, 15));
            rd   = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            funct = 6'($urandom_range(0, 63));
            case (kind)
                0, 1: begin
                    op  = 2'b00;
                    cmd = cmds[$urandom_range(0, 5)];
                    if (cmd == 4'd7) cmd = 4'($urandom_range(0, 15));
                    funct = {(kind == 1), cmd, (cmd == 4'd10) ? 1'b1 : funct[0]};
                end
                2: begin op = 2'b01; funct[0] = 1'b1; end
                3: begin op = 2'b01; funct[0] = 1'b0; end
                4: op = 2'b10;
                default: op = 2'b11;
            endcase
            run_instr({cond, op, funct, 4'($urandom_range(0, 15)), rd}, 1'b0, 4'h0, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
